// File: rtl/dec5_digit_sequencer_pkg.sv
// Shared constants and state type for the BCD digit sequencer and the display path.
package dec5_digit_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Start-to-ready cycle count of the serial div16by10 unit.
  localparam int DIV_LATENCY = 17;

  // Digit slots needed for a full 16-bit value (65535).
  localparam int NDIGITS_DEF = 5;

  // Code for a blanked leading digit; the display decoder renders it as off.
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  // Longest WAIT stay tolerated before giving up on the divider.
  localparam int WATCHDOG_DEF = 20;

endpackage

// File: rtl/dec5_digit_sequencer.sv
// Drives the shared divide-by-ten unit repeatedly to turn a 16-bit value into
// BCD digits, least-significant digit first.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; results from the last conversion hold
// LAUNCH | one-cycle div_start with the current work value
// WAIT   | counting until div_ready, or until the watchdog expires
// DONE   | one-cycle done pulse, then back to IDLE
module dec5_digit_sequencer
  import dec5_digit_sequencer_pkg::*;
#(
  parameter int         NDIGITS    = NDIGITS_DEF,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF,
  parameter int         WATCHDOG   = WATCHDOG_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [15:0]            req_value,
  input  logic                   req_blank,
  output logic                   req_ready,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic [2:0]             digit_count,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  output logic                   div_start,
  output logic [15:0]            div_dividend,
  input  logic [15:0]            div_quotient,
  input  logic [3:0]             div_remainder,
  input  logic                   div_ready
);

  localparam logic [2:0] LAST_K = 3'(NDIGITS - 1);
  localparam logic [4:0] WD_LIM = 5'(WATCHDOG);

  seq_state_e           state_q, state_d;
  logic [4*NDIGITS-1:0] bcd_q, bcd_d;
  logic [2:0]           dc_q, dc_d;
  logic                 err_q, err_d;
  logic [15:0]          work_q, work_d;
  logic [2:0]           k_q, k_d;
  logic [4:0]           wait_q, wait_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      dc_q    <= '0;
      err_q   <= 1'b0;
      work_q  <= '0;
      k_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      dc_q    <= dc_d;
      err_q   <= err_d;
      work_q  <= work_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and datapath updates; div_ready is only trusted in WAIT because
  // the free-running divider also pulses ready on its own.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    dc_d    = dc_q;
    err_d   = err_q;
    work_d  = work_q;
    k_d     = k_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          work_d = req_value;
          k_d    = '0;
          err_d  = 1'b0;
          for (int i = 0; i < NDIGITS; i++) begin
            bcd_d[4*i +: 4] = req_blank ? BLANK_CODE : 4'h0;
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q + 5'd1;
        if (div_ready) begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (k_q == 3'(i)) bcd_d[4*i +: 4] = div_remainder;
          end
          work_d = div_quotient;
          if ((div_quotient == 16'd0) || (k_q == LAST_K)) begin
            dc_d    = k_q + 3'd1;
            state_d = DONE;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = LAUNCH;
          end
        end else if (wait_d == WD_LIM) begin
          err_d   = 1'b1;
          dc_d    = k_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign div_start    = (state_q == LAUNCH);
  assign div_dividend = work_q;
  assign bcd          = bcd_q;
  assign digit_count  = dc_q;
  assign err          = err_q;

endmodule

// File: doc/dec5_digit_sequencer.md
Name: dec5_digit_sequencer

Overview:
- Converts a 16-bit unsigned value into up to 5 BCD digits by driving the shared serial divide-by-ten unit (div16by10) repeatedly.
- Each pass yields one remainder, the least-significant digit first; the quotient is fed back as the next dividend.
- Sits between number producers (e.g. MIDI/counter display logic) and the 7-segment/text display path.
- Owns the divider's start/dividend inputs exclusively; the divider is instantiated beside it in the parent.

Parameters:
- NDIGITS, 5, maximum digits produced (5 covers 65535).
- BLANK_CODE, 4'hF, code written to unused leading digit slots when blanking is enabled.
- WATCHDOG, 20, WAIT-state cycle limit before the error exit.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  conversion request.
- req_value  in  16  value to convert, sampled on acceptance.
- req_blank  in  1  leading-zero blanking enable, sampled on acceptance.
- req_ready  out  1  high only in IDLE; acceptance = req_valid & req_ready.
- bcd  out  4*NDIGITS  digit k in bits [4k+3:4k], k=0 is the least-significant digit.
- digit_count  out  3  significant digits produced, 1..NDIGITS.
- done  out  1  one-cycle pulse; bcd/digit_count/err valid from this cycle onward.
- err  out  1  watchdog fired on this conversion; valid with done.
- busy  out  1  high in all states except IDLE.
- div_start  out  1  combinational, high exactly in LAUNCH.
- div_dividend  out  16  registered current work value.
- div_quotient  in  16  divider quotient.
- div_remainder  in  4  divider remainder, 0..9.
- div_ready  in  1  divider ready.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bcd=0, digit_count=0, done=0, err=0, busy=0, work=0, digit index k=0.
- The divider has no reset and free-runs. Its ready is high for one cycle only (its bit counter wraps 0->31), and is also high at power-up. The controller therefore samples div_ready only in WAIT.
- States:
  - IDLE: on acceptance, latch work=req_value and blank=req_blank; set k=0, err=0; preset every bcd slot to BLANK_CODE if blank, else 0; go to LAUNCH. A request with req_valid high in any other state is not accepted and must be held by the requester.
  - LAUNCH: div_start=1 for exactly one cycle; div_dividend=work; clear the wait counter; go to WAIT.
  - WAIT: increment the wait counter. When div_ready=1:
    - write bcd[k]=div_remainder and work=div_quotient;
    - if div_quotient==0 or k==NDIGITS-1: digit_count=k+1 and go to DONE;
    - else k=k+1 and go to LAUNCH.
    - If the wait counter reaches WATCHDOG without div_ready: err=1, digit_count=k, go to DONE.
  - DONE: done=1 for one cycle; go to IDLE. Outputs hold until the next acceptance.
- Timing, with acceptance in cycle A:
  - LAUNCH for digit n (n=0..) is in cycle A+1+18n.
  - div_ready is expected 17 cycles after that LAUNCH cycle.
  - The capture edge for digit n closes cycle A+18(n+1).
  - done is high in cycle A+18*digit_count+1.
  - The next acceptance is possible 2 cycles after the final capture.
- Value 0: one pass, bcd[0]=0 regardless of blanking, digit_count=1.
- Capture width: quotient is always 16 bits. Remainder >9 indicates a divider fault; it is stored unchanged and not flagged.
- Reset mid-conversion: immediate return to IDLE with reset values; the divider's later ready pulse is ignored because the state is not WAIT.
- No back-to-back acceptance from DONE; one idle cycle is guaranteed between conversions.

Decomposition:
- Shared package:
  - state enum {IDLE, LAUNCH, WAIT, DONE}, 2 bits;
  - DIV_LATENCY=17, the expected start-to-ready cycles of div16by10;
  - default BLANK_CODE and NDIGITS constants, also used by the display decoder.
- No sub-module. The divider stays a sibling instance so it can later be shared through an arbiter. The controller is one FSM plus counters (k: 3 bits; wait counter: 5 bits).

Test Plan:
- Reset, then req_value=0, blank=1 -> bcd=0xFFFF0, digit_count=1, done at A+19, err=0.
- req_value=65535 -> bcd=0x65535, digit_count=5, done exactly at A+91, five div_start pulses spaced 18 cycles apart.
- req_value=1234: blank=1 -> bcd=0xF1234, digit_count=4; blank=0 -> bcd=0x01234.
- Second req_valid asserted while busy -> req_ready=0 and it is not accepted; the value is accepted in the first IDLE cycle after done, and the first result is unchanged.
- Reset asserted 30 cycles into converting 65535 -> next cycle IDLE, bcd=0, busy=0; the later divider ready pulse causes no change and done never pulses.
- Divider model with ready stuck low -> err=1, done at WAIT cycle 20 of the first digit, digit_count=0.
